cache_mem_ctrl: RTL
===================

Name: cache_mem_ctrl

Overview:
- Miss/eviction handler directly downstream of sa_cache.
- Consumes the cache's cache_miss, o_evict, o_evict_addr and o_evict_data outputs.
- Writes back the evicted line to backing memory, then fetches the missing line and returns it on the cache's i_memory_line/i_memory_response inputs.
- One outstanding transaction; a per-request timeout with bounded retry guarantees the cache never hangs.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for mem_ack before abandoning an attempt (1..255).
- MAX_RETRY, 2: extra attempts after the first timeout before reporting an error (0..7).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_cache_miss  in  1  level; held by the cache until o_mem_response.
- i_miss_addr  in  32  {tag[17:0], index[7:0], offset[5:0]} of the missing access.
- i_evict  in  1  dirty eviction accompanies this request.
- i_evict_addr  in  32  line address of the evicted line.
- i_evict_data  in  32  evicted line data.
- o_mem_line  out  32  fill data to the cache (i_memory_line).
- o_mem_response  out  1  one-cycle fill-complete pulse (i_memory_response).
- o_busy  out  1  transaction in progress.
- o_error  out  1  one-cycle pulse, coincident with the failing o_mem_response or the end of a failed writeback.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_ack  in  1  memory accepts the request (write done / read data valid).
- mem_rdata  in  32  read data, valid when mem_ack = 1 on a read.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE. All outputs 0. Retry and timeout counters 0. Latched address/data registers 0.
- All outputs are registered.
- States: IDLE, WB, FILL, BACKOFF, RESP.
- IDLE:
  - Samples i_cache_miss and i_evict on every edge.
  - On the first edge where either is 1: latch the miss address (offset bits forced to 0), evict address, evict data and both flags; set o_busy = 1.
  - If the evict flag is set: go to WB. Otherwise, if the miss flag is set: go to FILL.
- Inputs are ignored in every state except IDLE.
- WB: mem_req = 1, mem_we = 1, mem_addr = evict addr, mem_wdata = evict data.
  - On the mem_ack edge: deassert mem_req next cycle; clear the retry counter.
  - Then FILL if the miss flag is set, else IDLE with o_busy = 0.
- FILL: mem_req = 1, mem_we = 0, mem_addr = {tag, index, 6'b0}.
  - On the mem_ack edge: capture mem_rdata into o_mem_line; go to RESP.
- RESP: o_mem_response = 1 for exactly one cycle; then IDLE with o_busy = 0. o_mem_line holds its value until the next fill.
- Latency with ack on the first request cycle:
  - Fill only: miss accepted at edge 0, mem_req high cycles 1..k (ack at edge k), o_mem_response high in cycle k+1.
  - Writeback adds the writeback handshake cycles, plus 1 cycle with mem_req low between the write and the read.
- mem_req protocol: while mem_req = 1, mem_addr, mem_we and mem_wdata are stable. mem_ack while mem_req = 0 is ignored.
- Timeout:
  - An 8-bit counter increments every cycle in WB/FILL without mem_ack and clears on state entry.
  - Reaching TIMEOUT_CYCLES: drop mem_req; go to BACKOFF for 1 cycle; increment the retry counter; return to the same state (WB or FILL).
  - Once the retry counter exceeds MAX_RETRY:
    - FILL: go to RESP with o_mem_line = 0 and o_error = 1 alongside o_mem_response.
    - WB: pulse o_error, skip the writeback, continue to FILL or IDLE as for success.
  - The retry counter clears on every successful ack.
- Simultaneous i_cache_miss and i_evict: writeback strictly precedes the fill.
- i_evict without i_cache_miss: writeback only; no o_mem_response.
- mem_ack on the same edge as a timeout: ack wins.
- Reset mid-transaction: immediate return to IDLE, mem_req drops asynchronously, the in-flight transaction is abandoned, no response pulse.

Test Plan:
- Fill-only read: miss_addr = 0x1234_5678, memory acks on the 3rd req cycle with rdata = 0xDEAD_BEEF.
  - Expect mem_addr = 0x1234_5640, mem_we = 0.
  - Expect o_mem_line = 0xDEAD_BEEF with a 1-cycle o_mem_response.
- Miss plus eviction: evict_addr = 0x0000_0100, evict_data = 0xCAFE_F00D, miss_addr = 0x0000_0200.
  - Expect a write of 0xCAFE_F00D to 0x100 first, then 1 idle cycle, then a read from 0x200, then the response.
- Eviction only: i_evict = 1, i_cache_miss = 0.
  - Expect one write.
  - Expect no o_mem_response; o_busy falls after the ack.
- Timeout and retry: TIMEOUT_CYCLES = 4, MAX_RETRY = 2, memory never acks a fill.
  - Expect 3 request bursts of 4 cycles, each separated by 1 low cycle.
  - Then o_mem_response = 1, o_error = 1, o_mem_line = 0.
- Recovery on retry: ack on the second attempt with rdata = 0x5A5A_5A5A. Expect a normal response with o_error = 0.
- Reset during FILL: assert rst low mid-burst.
  - Expect mem_req low immediately and all outputs 0.
  - After release, a new miss is served normally.

Source files
------------

// File: rtl/cache_mem_ctrl_if.sv
// Bus bundle between sa_cache, the miss/eviction controller and backing memory.
// Cache side : i_cache_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data
//              in; o_mem_line, o_mem_response, o_busy, o_error out.
// Memory side: mem_req, mem_we, mem_addr, mem_wdata out; mem_ack, mem_rdata in.
// Modport master is the controller's view; slave is the cache/memory view.
interface cache_mem_ctrl_if;
  logic        i_cache_miss;
  logic [31:0] i_miss_addr;
  logic        i_evict;
  logic [31:0] i_evict_addr;
  logic [31:0] i_evict_data;
  logic [31:0] o_mem_line;
  logic        o_mem_response;
  logic        o_busy;
  logic        o_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  i_cache_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    input  mem_ack, mem_rdata,
    output o_mem_line, o_mem_response, o_busy, o_error,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_cache_miss, i_miss_addr, i_evict, i_evict_addr, i_evict_data,
    output mem_ack, mem_rdata,
    input  o_mem_line, o_mem_response, o_busy, o_error,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_mem_ctrl.sv
// Miss/eviction handler behind sa_cache. Writes back a dirty evicted line,
// then fetches the missing line and returns it with a one-cycle response.
// One transaction at a time; each memory attempt times out after
// TIMEOUT_CYCLES and is retried up to MAX_RETRY extra times before o_error.
// Ports: clk, rst (async, active-low), bus (cache_mem_ctrl_if.master).
// All outputs are registered.
module cache_mem_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 2
) (
  input logic              clk,
  input logic              rst,
  cache_mem_ctrl_if.master bus
);
  localparam logic [7:0] TMO_LIM   = 8'(TIMEOUT_CYCLES);
  localparam logic [3:0] RETRY_LIM = 4'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, WB, FILL, BACKOFF, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] miss_addr_q, miss_addr_d;
  logic [31:0] evict_addr_q, evict_addr_d;
  logic [31:0] evict_data_q, evict_data_d;
  logic        miss_flag_q, miss_flag_d;
  logic        evict_flag_q, evict_flag_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic [31:0] line_q, line_d;
  logic        resp_q, resp_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ack;
  logic        tmo_hit;
  logic        retry_out;
  logic        wb_done;
  logic [7:0]  tmo_next;
  logic [3:0]  retry_next;

  assign ack        = req_q & bus.mem_ack;
  assign tmo_next   = tmo_cnt_q + 8'd1;
  assign tmo_hit    = (tmo_next == TMO_LIM);
  assign retry_next = retry_q + 4'd1;
  assign retry_out  = (retry_next > RETRY_LIM);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    evict_addr_d = evict_addr_q;
    evict_data_d = evict_data_q;
    miss_flag_d  = miss_flag_q;
    evict_flag_d = evict_flag_q;
    tmo_cnt_d    = tmo_cnt_q;
    retry_d      = retry_q;
    line_d       = line_q;
    resp_d       = 1'b0;
    error_d      = 1'b0;
    busy_d       = busy_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wb_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_cache_miss || bus.i_evict) begin
          miss_addr_d  = bus.i_miss_addr & 32'hFFFF_FFC0;
          evict_addr_d = bus.i_evict_addr;
          evict_data_d = bus.i_evict_data;
          miss_flag_d  = bus.i_cache_miss;
          evict_flag_d = bus.i_evict;
          busy_d       = 1'b1;
          tmo_cnt_d    = 8'd0;
          retry_d      = 4'd0;
          req_d        = 1'b1;
          if (bus.i_evict) begin
            state_d = WB;
            we_d    = 1'b1;
            addr_d  = bus.i_evict_addr;
            wdata_d = bus.i_evict_data;
          end else begin
            state_d = FILL;
            we_d    = 1'b0;
            addr_d  = bus.i_miss_addr & 32'hFFFF_FFC0;
          end
        end
      end

      WB: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (ack) begin
          req_d   = 1'b0;
          retry_d = 4'd0;
          wb_done = 1'b1;
        end else if (tmo_hit) begin
          req_d = 1'b0;
          if (retry_out) begin
            retry_d = 4'd0;
            error_d = 1'b1;
            wb_done = 1'b1;
          end else begin
            retry_d = retry_next;
            state_d = BACKOFF;
          end
        end else begin
          tmo_cnt_d = tmo_next;
        end
        // The fill reuses BACKOFF as its one idle cycle after the write.
        if (wb_done) begin
          evict_flag_d = 1'b0;
          if (miss_flag_q) begin
            state_d = BACKOFF;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      FILL: begin
        if (ack) begin
          req_d   = 1'b0;
          retry_d = 4'd0;
          line_d  = bus.mem_rdata;
          resp_d  = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          req_d = 1'b0;
          if (retry_out) begin
            retry_d = 4'd0;
            line_d  = 32'd0;
            resp_d  = 1'b1;
            error_d = 1'b1;
            state_d = RESP;
          end else begin
            retry_d = retry_next;
            state_d = BACKOFF;
          end
        end else begin
          tmo_cnt_d = tmo_next;
        end
      end

      BACKOFF: begin
        // The evict flag is cleared once the writeback finishes, so it
        // selects which phase to (re)enter.
        tmo_cnt_d = 8'd0;
        req_d     = 1'b1;
        if (evict_flag_q) begin
          state_d = WB;
          we_d    = 1'b1;
          addr_d  = evict_addr_q;
          wdata_d = evict_data_q;
        end else begin
          state_d = FILL;
          we_d    = 1'b0;
          addr_d  = miss_addr_q;
        end
      end

      RESP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      miss_addr_q  <= 32'd0;
      evict_addr_q <= 32'd0;
      evict_data_q <= 32'd0;
      miss_flag_q  <= 1'b0;
      evict_flag_q <= 1'b0;
      tmo_cnt_q    <= 8'd0;
      retry_q      <= 4'd0;
      line_q       <= 32'd0;
      resp_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      miss_addr_q  <= miss_addr_d;
      evict_addr_q <= evict_addr_d;
      evict_data_q <= evict_data_d;
      miss_flag_q  <= miss_flag_d;
      evict_flag_q <= evict_flag_d;
      tmo_cnt_q    <= tmo_cnt_d;
      retry_q      <= retry_d;
      line_q       <= line_d;
      resp_q       <= resp_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.o_mem_line     = line_q;
  assign bus.o_mem_response = resp_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_error        = error_q;
  assign bus.mem_req        = req_q;
  assign bus.mem_we         = we_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wdata      = wdata_q;
endmodule
